regfile_write_queue: RTL and testbench

- Write-side feeder that sits directly upstream of the 32x32 RegisterFile and drives its write port (write address, write data, Write_Reg).
- After reset it runs an init sweep that zeroes r1..r31. It then accepts write requests over a valid/ready handshake and buffers them in a small FIFO. It retires at most one write per cycle.
- It provides a combinational lookup port so that readers can obtain data still pending in the queue (forwarding).

---
 rtl/regfile_write_queue_pkg.sv | 15 +
 rtl/regfile_write_queue_fifo.sv | 83 ++++++++
 rtl/regfile_write_queue.sv | 138 +++++++++++++
 tb/tb_regfile_write_queue.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_queue_pkg.sv
// Shared constants and FSM encoding for the register-file write queue.
package regfile_write_queue_pkg;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int REG_COUNT  = 32;
    localparam int SWEEP_LAST = REG_COUNT - 1;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DROP_W     = 8;

endpackage

// File: rtl/regfile_write_queue_fifo.sv
// Pending-write FIFO: storage, pointers, occupancy and an age-ordered entry view.
module wq_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] ent_addr  [DEPTH],
    output logic [DATA_W-1:0] ent_data  [DEPTH],
    output logic [DEPTH-1:0]  ent_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // The caller never pushes when full nor pops when empty.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            addr_mem_d[wr_ptr_q] = push_addr;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entry i is the i-th oldest pending write; index 0 is the head.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i]  = addr_mem_q[rd_ptr_q + PTR_W'(i)];
            ent_data[i]  = data_mem_q[rd_ptr_q + PTR_W'(i)];
            ent_valid[i] = (CNT_W'(i) < count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; ent_valid masks stale slots, so clearing it would only cost area.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Write-port feeder for the 32x32 RegisterFile: init sweep, queued writes, forwarding lookup.
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [ADDR_W-1:0] In_Addr,
    input  logic [DATA_W-1:0] In_Data,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    input  logic [ADDR_W-1:0] Lookup_Addr,
    output logic              Hit,
    output logic [DATA_W-1:0] Hit_Data,
    output logic              Sweep_Done,
    output logic [DROP_W-1:0] Drop_Count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              write_reg_q, write_reg_d;
    logic              sweep_done_q, sweep_done_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;

    logic              accept, push, pop;
    logic              fifo_full, fifo_empty;
    logic [ADDR_W-1:0] ent_addr  [DEPTH];
    logic [DATA_W-1:0] ent_data  [DEPTH];
    logic [DEPTH-1:0]  ent_valid;

    wq_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
        .clk       (Clk),
        .reset     (Reset),
        .push      (push),
        .push_addr (In_Addr),
        .push_data (In_Data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_valid (ent_valid)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_SWEEP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_SWEEP && sweep_addr_q == ADDR_W'(SWEEP_LAST)) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        sweep_addr_d = sweep_addr_q;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        write_reg_d  = 1'b0;
        sweep_done_d = sweep_done_q;
        drop_count_d = drop_count_q;

        In_Ready = (state_q == ST_RUN) && !fifo_full;
        accept   = In_Valid && In_Ready;
        push     = accept && (In_Addr != '0);
        pop      = (state_q == ST_RUN) && !fifo_empty;

        if (state_q == ST_SWEEP) begin
            w_addr_d     = sweep_addr_q;
            w_data_d     = '0;
            write_reg_d  = 1'b1;
            sweep_addr_d = sweep_addr_q + 1'b1;
            if (sweep_addr_q == ADDR_W'(SWEEP_LAST)) sweep_done_d = 1'b1;
        end else if (pop) begin
            w_addr_d    = ent_addr[0];
            w_data_d    = ent_data[0];
            write_reg_d = 1'b1;
        end

        // r0 writes complete the handshake but are only counted.
        if (accept && In_Addr == '0 && drop_count_q != '1) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sweep_addr_q <= ADDR_W'(1);
            w_addr_q     <= '0;
            w_data_q     <= '0;
            write_reg_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            sweep_addr_q <= sweep_addr_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            write_reg_q  <= write_reg_d;
            sweep_done_q <= sweep_done_d;
            drop_count_q <= drop_count_d;
        end
    end

    // NOTE: candidates are scanned oldest to youngest with blocking assignments, so the last match wins.
    always_comb begin
        Hit      = 1'b0;
        Hit_Data = '0;
        if (state_q == ST_RUN && Lookup_Addr != '0) begin
            if (write_reg_q && w_addr_q == Lookup_Addr) begin
                Hit      = 1'b1;
                Hit_Data = w_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i] && ent_addr[i] == Lookup_Addr) begin
                    Hit      = 1'b1;
                    Hit_Data = ent_data[i];
                end
            end
        end
    end

    assign W_Addr     = w_addr_q;
    assign W_Data     = w_data_q;
    assign Write_Reg  = write_reg_q;
    assign Sweep_Done = sweep_done_q;
    assign Drop_Count = drop_count_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue with a queue-based reference model checked every cycle.
module tb_regfile_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          In_Valid;
    logic          In_Ready;
    logic [AW-1:0] In_Addr;
    logic [DW-1:0] In_Data;
    logic [AW-1:0] W_Addr;
    logic [DW-1:0] W_Data;
    logic          Write_Reg;
    logic [AW-1:0] Lookup_Addr;
    logic          Hit;
    logic [DW-1:0] Hit_Data;
    logic          Sweep_Done;
    logic [7:0]    Drop_Count;

    always #5 Clk = ~Clk;

    regfile_write_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .In_Addr     (In_Addr),
        .In_Data     (In_Data),
        .W_Addr      (W_Addr),
        .W_Data      (W_Data),
        .Write_Reg   (Write_Reg),
        .Lookup_Addr (Lookup_Addr),
        .Hit         (Hit),
        .Hit_Data    (Hit_Data),
        .Sweep_Done  (Sweep_Done),
        .Drop_Count  (Drop_Count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a plain queue plus the write-port register.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          m_pend[$];
    bit            m_valid = 1'b0;
    bit            m_done;
    bit            m_wreg;
    int            m_sweep;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_drop;
    int            cyc_cnt = 0;

    initial begin
        ent_t e;
        bit   acc;
        forever begin
            @(posedge Clk);
            cyc_cnt++;
            if (Reset) begin
                m_valid = 1'b1;
                m_done  = 1'b0;
                m_wreg  = 1'b0;
                m_sweep = 1;
                m_waddr = '0;
                m_wdata = '0;
                m_drop  = 0;
                m_pend.delete();
            end else if (m_valid) begin
                if (!m_done) begin
                    m_wreg  = 1'b1;
                    m_waddr = m_sweep[AW-1:0];
                    m_wdata = '0;
                    if (m_sweep == 31) m_done = 1'b1;
                    m_sweep++;
                end else begin
                    acc = In_Valid && (m_pend.size() < DEPTH);
                    if (m_pend.size() > 0) begin
                        e       = m_pend.pop_front();
                        m_wreg  = 1'b1;
                        m_waddr = e.a;
                        m_wdata = e.d;
                    end else begin
                        m_wreg = 1'b0;
                    end
                    if (acc) begin
                        if (In_Addr == '0) begin
                            if (m_drop < 255) m_drop++;
                        end else begin
                            m_pend.push_back('{In_Addr, In_Data});
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        bit            exp_rdy;
        bit            exp_hit;
        logic [DW-1:0] exp_hd;
        forever begin
            @(negedge Clk);
            if (m_valid) begin
                exp_rdy = m_done && (m_pend.size() < DEPTH);
                exp_hit = 1'b0;
                exp_hd  = '0;
                if (m_done && Lookup_Addr != '0) begin
                    if (m_wreg && m_waddr == Lookup_Addr) begin
                        exp_hit = 1'b1;
                        exp_hd  = m_wdata;
                    end
                    foreach (m_pend[i]) begin
                        if (m_pend[i].a == Lookup_Addr) begin
                            exp_hit = 1'b1;
                            exp_hd  = m_pend[i].d;
                        end
                    end
                end
                check("mdl_write_reg",  Write_Reg,  m_wreg);
                check("mdl_w_addr",     W_Addr,     m_waddr);
                check("mdl_w_data",     W_Data,     m_wdata);
                check("mdl_in_ready",   In_Ready,   exp_rdy);
                check("mdl_sweep_done", Sweep_Done, m_done);
                check("mdl_drop_count", Drop_Count, m_drop);
                check("mdl_hit",        Hit,        exp_hit);
                check("mdl_hit_data",   Hit_Data,   exp_hd);
            end
        end
    end

    // Pulse log used by the hand-computed expectations.
    logic [AW-1:0] log_a[$];
    logic [DW-1:0] log_d[$];
    bit            log_sd[$];
    int            log_t[$];

    initial begin
        forever begin
            @(negedge Clk);
            if (Write_Reg === 1'b1) begin
                log_a.push_back(W_Addr);
                log_d.push_back(W_Data);
                log_sd.push_back(Sweep_Done);
                log_t.push_back(cyc_cnt);
            end
        end
    end

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_sd.delete();
        log_t.delete();
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_sweep_log(input string name);
        int bad;
        int first_sd;
        bad      = 0;
        first_sd = -1;
        check({name, "_pulses"}, log_a.size(), 31);
        foreach (log_a[i]) begin
            if (log_a[i] != AW'(i + 1) || log_d[i] != '0) bad++;
            if (log_sd[i] && first_sd < 0) first_sd = i;
        end
        check({name, "_order"}, bad, 0);
        check({name, "_done_at_addr31"}, first_sd, 30);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        int bad;
        int lowcnt;
        bit rdy;

        Reset       = 1'b1;
        In_Valid    = 1'b0;
        In_Addr     = '0;
        In_Data     = '0;
        Lookup_Addr = '0;
        step();
        step();
        check("rst_write_reg",  Write_Reg,  1'b0);
        check("rst_w_addr",     W_Addr,     '0);
        check("rst_w_data",     W_Data,     '0);
        check("rst_sweep_done", Sweep_Done, 1'b0);
        check("rst_drop_count", Drop_Count, 8'd0);
        check("rst_in_ready",   In_Ready,   1'b0);

        // Init sweep
        Reset = 1'b0;
        clear_log();
        repeat (35) step();
        check_sweep_log("sweep");
        check("sweep_done_hi", Sweep_Done, 1'b1);
        check("run_in_ready",  In_Ready,   1'b1);

        // Single write latency
        clear_log();
        In_Valid = 1'b1;
        In_Addr  = 5'd5;
        In_Data  = 32'h0000_0607;
        check("single_ready", In_Ready, 1'b1);
        step();
        In_Valid = 1'b0;
        check("single_not_yet", Write_Reg, 1'b0);
        step();
        check("single_wreg", Write_Reg, 1'b1);
        check("single_addr", W_Addr,    5'd5);
        check("single_data", W_Data,    32'h0000_0607);
        step();
        check("single_after", Write_Reg, 1'b0);
        check("single_count", log_a.size(), 1);

        // Back-to-back burst
        clear_log();
        In_Valid = 1'b1;
        idx      = 0;
        cyc      = 0;
        while (idx < DEPTH + 3 && cyc < 100) begin
            In_Addr = AW'(10 + idx);
            In_Data = 32'hA000_0000 + 32'(idx);
            rdy     = In_Ready;
            step();
            if (rdy) idx++;
            cyc++;
        end
        In_Valid = 1'b0;
        repeat (3) step();
        check("burst_accepted", idx, DEPTH + 3);
        check("burst_pulses", log_a.size(), DEPTH + 3);
        bad = 0;
        foreach (log_a[i]) begin
            if (log_a[i] != AW'(10 + i) || log_d[i] != 32'hA000_0000 + 32'(i)) bad++;
        end
        check("burst_order", bad, 0);
        if (log_t.size() == DEPTH + 3) begin
            check("burst_rate", log_t[DEPTH + 2] - log_t[0], DEPTH + 2);
        end

        // Forwarding lookup
        In_Valid = 1'b1;
        In_Addr  = 5'd7;
        In_Data  = 32'h0000_0003;
        step();
        In_Addr     = 5'd9;
        In_Data     = 32'hFFFF_FFFF;
        Lookup_Addr = 5'd7;
        #1;
        check("lk1_hit",  Hit,      1'b1);
        check("lk1_data", Hit_Data, 32'h0000_0003);
        step();
        In_Addr = 5'd7;
        In_Data = 32'h1111_1234;
        #1;
        check("lk2_data", Hit_Data, 32'h0000_0003);
        step();
        In_Valid = 1'b0;
        #1;
        check("lk3_hit",  Hit,      1'b1);
        check("lk3_data", Hit_Data, 32'h1111_1234);
        Lookup_Addr = 5'd9;
        #1;
        check("lk9_data", Hit_Data, 32'hFFFF_FFFF);
        Lookup_Addr = 5'd8;
        #1;
        check("lk8_hit",  Hit,      1'b0);
        check("lk8_data", Hit_Data, 32'h0);
        Lookup_Addr = 5'd0;
        #1;
        check("lk0_hit", Hit, 1'b0);
        Lookup_Addr = 5'd7;
        step();
        check("lk4_data", Hit_Data, 32'h1111_1234);
        step();
        check("lk5_hit", Hit, 1'b0);
        Lookup_Addr = 5'd0;
        step();

        // r0 drops, saturating counter
        clear_log();
        In_Valid = 1'b1;
        In_Addr  = 5'd0;
        lowcnt   = 0;
        repeat (300) begin
            In_Data = $urandom;
            if (!In_Ready) lowcnt++;
            step();
        end
        In_Valid = 1'b0;
        step();
        check("drop_ready_low", lowcnt, 0);
        check("drop_no_writes", log_a.size(), 0);
        check("drop_saturated", Drop_Count, 8'd255);

        // Reset with writes pending
        In_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            In_Addr = AW'(20 + i);
            In_Data = 32'hDEAD_0000 + 32'(i);
            step();
        end
        In_Valid = 1'b0;
        Reset    = 1'b1;
        step();
        clear_log();
        check("mid_rst_wreg",  Write_Reg,  1'b0);
        check("mid_rst_done",  Sweep_Done, 1'b0);
        check("mid_rst_drop",  Drop_Count, 8'd0);
        check("mid_rst_ready", In_Ready,   1'b0);
        Reset = 1'b0;
        repeat (35) step();
        check_sweep_log("resweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
